pipelined_data_memory: RTL
==========================

// Module: pipelined_data_memory
// PURPOSE
//  Parametrised, pipelined data memory for the MEM stage; successor to the single-cycle data memory.
//  Valid/ready request port, per-byte write strobes, fixed READ_LATENCY in-order responses, pipeline stall, misalignment fault.
//  Contents zeroed by a sweep FSM after reset instead of a reset-time loop.
// PARAMETERS
//  DM_WORDS      1024  depth in 32-bit words; power of two, >= 4
//  READ_LATENCY  2     accept-to-resp_valid cycles, legal 1..4
// PORTS
//  clock        in   1         single clock, rising edge
//  reset        in   1         asynchronous, active-high
//  pc_value     in   32        PC of requesting instruction (fault reporting only)
//  req_valid    in   1         request present
//  req_ready    out  1         block can accept this cycle
//  req_write    in   1         1 = store, 0 = load
//  address      in   32        byte address
//  read_type    in   read_type_t   load width/sign
//  write_type   in   write_type_t  store width
//  write_value  in   32        store data, right-aligned
//  stall        in   1         freeze read pipeline, block new requests
//  resp_valid   out  1         load response (or faulted access) present
//  read_result  out  32        extended load data
//  resp_fault   out  dm_fault_t  NONE / MISALIGNED / OUT_OF_RANGE
//  fault_pc     out  32        pc_value of the faulting access
// BEHAVIOUR
//  Reset (async): state<=CLEAR, sweep index<=0, all pipe valids<=0; outputs: req_ready=0, resp_valid=0, read_result=0, resp_fault=NONE, fault_pc=0.
//  FSM CLEAR: write 0 to word[idx], idx++ each cycle; after idx==DM_WORDS-1 -> READY (exactly DM_WORDS cycles).
//  FSM READY: req_ready = !stall. Reset asserted mid-operation -> back to CLEAR, in-flight responses dropped.
//  Accept = req_valid & req_ready. Word index = address[31:2] & (DM_WORDS-1).
//  Store: byte strobes from write_type/address[1:0]; array updated at the accepting edge; no response unless faulted.
//  Load: array read at accept, result aligned/extended, delivered READ_LATENCY cycles later, in order.
//  Same-address load accepted the cycle after a store returns the new data; load+store same cycle impossible (one port).
//  stall=1: pipeline registers and resp_valid/read_result hold; no accept; array untouched.
//  Misaligned: half-word with address[0]=1, word with address[1:0]!=0 (load or store) -> no array write,
//   response issued at normal latency with read_result=0, resp_fault=MISALIGNED, fault_pc=pc_value.
//  WRITE_NONE with req_write=1: accepted, no-op, no response.
//  Byte lanes: lane n = bits [8n+7:8n]; half-word lane from address[1]; sign-extend from bit 7/15 for signed types.
// CONFIGURATION
//  DM_BOUNDS_CHECK_EN defined: address[31:2] >= DM_WORDS -> no write, response with resp_fault=OUT_OF_RANGE,
//   read_result=0 (misalignment takes priority if both).
//  Not defined: index masks silently (wrap-around); OUT_OF_RANGE never produced.
// STRUCTURE
//  Shared package (next to read_type_t/write_type_t): dm_fault_t enum, dm_state_t {CLEAR, READY},
//   N_BYTE/N_HALF_WORD lane constants, DM_MAX_READ_LATENCY=4.
//  Sub-module dm_load_align: combinational extract+extend of one word by read_type and address[1:0].
//  Top holds sweep FSM, strobe generation, array, READ_LATENCY-deep valid/data/fault shift pipeline.
// TESTING (DM_WORDS=16, READ_LATENCY=2)
//  Reset then wait: req_ready low exactly 16 cycles, then high; load word 0x3C -> 0x00000000 two cycles later.
//  Store word 0x12345678 @0x8; store byte 0xAB @0x9; load BYTE_SIGNED @0x9 -> 0xFFFFFFAB; ORIGIN_WORD -> 0x1234AB78.
//  Back-to-back loads @0x0,0x4,0x8 each cycle -> three consecutive resp_valid, in order; stall=1 for 3 cycles mid-stream
//   -> outputs hold, no loss, no duplication.
//  Load HALF_WORD @0x3 with pc_value=0x00400010 -> resp_fault=MISALIGNED, fault_pc=0x00400010, read_result=0, memory unchanged.
//  Store word @0x40: without DM_BOUNDS_CHECK_EN lands in word 0; with it -> OUT_OF_RANGE, word 0 unchanged.
//  Assert reset mid-stream with loads in flight -> resp_valid=0 immediately, sweep restarts, later reads return 0.

Source files
------------

// File: rtl/pipelined_data_memory_pkg.sv
// pipelined_data_memory_pkg: access types, fault codes, FSM states and response record
// shared by the pipelined data memory and its load aligner.
package pipelined_data_memory_pkg;
    typedef enum logic [2:0] {
        BYTE_SIGNED,
        BYTE_UNSIGNED,
        HALF_WORD_SIGNED,
        HALF_WORD_UNSIGNED,
        ORIGIN_WORD
    } read_type_t;

    typedef enum logic [1:0] {
        WRITE_NONE,
        WRITE_BYTE,
        WRITE_HALF_WORD,
        WRITE_WORD
    } write_type_t;

    typedef enum logic [1:0] {
        NONE,
        MISALIGNED,
        OUT_OF_RANGE
    } dm_fault_t;

    typedef enum logic {
        CLEAR,
        READY
    } dm_state_t;

    localparam int N_BYTE = 4;
    localparam int N_HALF_WORD = 2;
    localparam int DM_MAX_READ_LATENCY = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        dm_fault_t   fault;
        logic [31:0] pc;
    } dm_resp_t;

    function automatic logic is_misaligned(input logic write, input read_type_t rt,
                                           input write_type_t wt, input logic [1:0] offset);
        return write ? (wt == WRITE_HALF_WORD && offset[0]) || (wt == WRITE_WORD && offset != 2'b00)
                     : ((rt == HALF_WORD_SIGNED || rt == HALF_WORD_UNSIGNED) && offset[0]) ||
                       (rt == ORIGIN_WORD && offset != 2'b00);
    endfunction
endpackage

// File: rtl/pipelined_data_memory_load_align.sv
// dm_load_align: extracts the addressed byte/half-word from a memory word and
// zero- or sign-extends it according to the load type.
module dm_load_align
    import pipelined_data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  read_type_t  read_type,
    input  logic [1:0]  offset,
    output logic [31:0] result
);
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[{offset, 3'b000} +: 8];
        lane_half = word[{offset[1], 4'b0000} +: 16];
        result = read_type == BYTE_SIGNED        ? {{24{lane_byte[7]}}, lane_byte} :
                 read_type == BYTE_UNSIGNED      ? {24'h0, lane_byte} :
                 read_type == HALF_WORD_SIGNED   ? {{16{lane_half[15]}}, lane_half} :
                 read_type == HALF_WORD_UNSIGNED ? {16'h0, lane_half} : word;
    end
endmodule

// File: rtl/pipelined_data_memory.sv
// pipelined_data_memory: MEM-stage data memory with a post-reset clearing sweep, byte strobes,
// fixed-latency in-order responses and fault reporting. Define DM_BOUNDS_CHECK_EN for OUT_OF_RANGE faults.
module pipelined_data_memory
    import pipelined_data_memory_pkg::*;
#(
    parameter int DM_WORDS     = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_value,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] address,
    input  read_type_t  read_type,
    input  write_type_t write_type,
    input  logic [31:0] write_value,
    input  logic        stall,
    output logic        resp_valid,
    output logic [31:0] read_result,
    output dm_fault_t   resp_fault,
    output logic [31:0] fault_pc
);
    localparam int IW = $clog2(DM_WORDS);
    localparam int LAT = READ_LATENCY > DM_MAX_READ_LATENCY ? DM_MAX_READ_LATENCY : READ_LATENCY;
`ifdef DM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    dm_state_t         state;
    logic [IW-1:0]     idx;
    logic [31:0]       mem [DM_WORDS];
    dm_resp_t          pipe [LAT];
    dm_resp_t          next_resp;
    logic              accept, misaligned, out_of_range, faulted, write_en;
    logic [IW-1:0]     widx;
    logic [N_BYTE-1:0] strobe;
    logic [31:0]       wdata, loaded;

    assign req_ready    = state == READY && !stall;
    assign accept       = req_valid && req_ready;
    assign widx         = address[IW+1:2];
    assign misaligned   = is_misaligned(req_write, read_type, write_type, address[1:0]);
    assign out_of_range = BOUNDS_CHECK && address[31:2] >= 30'(DM_WORDS);
    assign faulted      = misaligned || out_of_range;
    assign write_en     = accept && req_write && !faulted;

    dm_load_align u_align (
        .word      (mem[widx]),
        .read_type (read_type),
        .offset    (address[1:0]),
        .result    (loaded)
    );

    // Store data is replicated across lanes so the strobes alone pick the target bytes.
    always_comb begin
        strobe = write_type == WRITE_WORD      ? {N_BYTE{1'b1}} :
                 write_type == WRITE_HALF_WORD ? 4'b0011 << {address[1], 1'b0} :
                 write_type == WRITE_BYTE      ? 4'b0001 << address[1:0] : 4'b0000;
        wdata  = write_type == WRITE_WORD      ? write_value :
                 write_type == WRITE_HALF_WORD ? {N_HALF_WORD{write_value[15:0]}} :
                                                 {N_BYTE{write_value[7:0]}};
        next_resp.valid = accept && (!req_write || faulted);
        next_resp.data  = next_resp.valid && !faulted ? loaded : 32'h0;
        next_resp.fault = !next_resp.valid ? NONE : misaligned ? MISALIGNED : out_of_range ? OUT_OF_RANGE : NONE;
        next_resp.pc    = next_resp.valid && faulted ? pc_value : 32'h0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            idx   <= '0;
        end else if (state == CLEAR) begin
            idx <= idx + 1'b1;
            if (idx == IW'(DM_WORDS - 1))
                state <= READY;
        end
    end

    always_ff @(posedge clock) begin
        if (state == CLEAR)
            mem[idx] <= '0;
        else if (write_en)
            for (int n = 0; n < N_BYTE; n++)
                if (strobe[n])
                    mem[widx][8*n +: 8] <= wdata[8*n +: 8];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++)
                pipe[i] <= '0;
        end else if (!stall) begin
            pipe[0] <= next_resp;
            for (int i = 1; i < LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign resp_valid  = pipe[LAT-1].valid;
    assign read_result = pipe[LAT-1].data;
    assign resp_fault  = pipe[LAT-1].fault;
    assign fault_pc    = pipe[LAT-1].pc;
endmodule
